// File: rtl/fp_norm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_norm_pkg
//  Description : Shared constants and state encoding for the floating-point
//                post-arithmetic normaliser (FP32 exponent field, packed
//                output field offsets, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_norm_pkg;

  // FP32 exponent/fraction geometry
  localparam int EXP_W     = 8;
  localparam int EXP_MAX   = 255;
  localparam int BIAS      = 127;
  localparam int FRAC_W    = 23;

  // Internal signed exponent width: wide enough for a 10-bit signed input
  // plus the single carry increment without wrapping.
  localparam int EXP_INT_W = 12;

  // Packed output field offsets, counted downward from the word MSB.
  localparam int SIGN_POS  = 0;
  localparam int EXP_HI    = 1;
  localparam int EXP_LO    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PACK  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/norm_pack.sv
`default_nettype none
// ============================================================================
//  Module      : norm_pack
//  Description : Combinational output formatter. Selects the exponent field
//                (zero for subnormal/zero, 255 + zero fraction on overflow),
//                aligns the fraction bits below the hidden bit into the
//                output fraction field and folds any surplus low bits into
//                the fraction LSB as sticky.
//  Ports       : sign_i      - result sign
//                exp_i       - signed internal exponent
//                frac_raw_i  - magnitude bits below the hidden bit
//                denorm_i    - result is subnormal or zero
//                data_o      - packed {sign, exp, frac}
//  Revision    : 1.0 - initial release
// ============================================================================
module norm_pack
  import fp_norm_pkg::*;
#(
  parameter int MAG_W  = 34,
  parameter int DATA_W = 40
) (
  input  logic                        sign_i,
  input  logic signed [EXP_INT_W-1:0] exp_i,
  input  logic [MAG_W-3:0]            frac_raw_i,
  input  logic                        denorm_i,
  output logic [DATA_W-1:0]           data_o
);

  localparam int F     = DATA_W - 1 - EXP_W;
  localparam int RAW_W = MAG_W - 2;

  logic [F-1:0]     frac_aligned;
  logic [EXP_W-1:0] exp_field;
  logic [F-1:0]     frac_field;

  generate
    if (RAW_W > F) begin : g_trunc
      localparam int SURPLUS = RAW_W - F;
      // Dropped low bits survive as sticky in the fraction LSB.
      assign frac_aligned = {frac_raw_i[RAW_W-1 -: F-1],
                             frac_raw_i[SURPLUS] | (|frac_raw_i[SURPLUS-1:0])};
    end else if (RAW_W < F) begin : g_pad
      assign frac_aligned = {frac_raw_i, {(F-RAW_W){1'b0}}};
    end else begin : g_exact
      assign frac_aligned = frac_raw_i;
    end
  endgenerate

  always_comb begin
    exp_field  = exp_i[EXP_W-1:0];
    frac_field = frac_aligned;
    if (denorm_i) begin
      exp_field = '0;
    end else if (exp_i >= EXP_MAX) begin
      exp_field  = EXP_W'(EXP_MAX);
      frac_field = '0;
    end
  end

  always_comb begin
    data_o = '0;
    data_o[DATA_W-1-SIGN_POS]                  = sign_i;
    data_o[DATA_W-1-EXP_HI : DATA_W-1-EXP_LO]  = exp_field;
    data_o[F-1:0]                              = frac_field;
  end

endmodule
`default_nettype wire

// File: rtl/float_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : float_normalizer
//  Description : Iterative post-arithmetic normaliser. Captures an
//                unnormalised sign/exponent/magnitude, shifts one bit per
//                cycle until the hidden bit is in place (or the result is
//                subnormal/zero), then registers a packed {sign, exp, frac}
//                word with the captured rounding mode.
//  Ports       : clk, rst             - clock, async active-high reset
//                in_valid/in_ready    - input handshake (ready only in IDLE)
//                in_sign/exp/mag/rmode- operation to normalise
//                out_valid/out_ready  - output handshake
//                out_data/out_rmode   - packed result and rounding mode
//  Revision    : 1.0 - initial release
// ============================================================================
module float_normalizer
  import fp_norm_pkg::*;
#(
  parameter int MAG_W  = 34,
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [9:0]        in_exp,
  input  logic [MAG_W-1:0]  in_mag,
  input  logic [1:0]        in_rmode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_rmode
);

  state_t                      state_q, state_d;
  logic                        sign_q, sign_d;
  logic signed [EXP_INT_W-1:0] exp_q, exp_d;
  logic [MAG_W-1:0]            mag_q, mag_d;
  logic [1:0]                  rmode_q, rmode_d;
  logic                        denorm_q, denorm_d;
  logic                        out_valid_q, out_valid_d;
  logic [DATA_W-1:0]           out_data_q, out_data_d;
  logic [DATA_W-1:0]           packed_word;

  norm_pack #(
    .MAG_W  (MAG_W),
    .DATA_W (DATA_W)
  ) u_norm_pack (
    .sign_i     (sign_q),
    .exp_i      (exp_q),
    .frac_raw_i (mag_q[MAG_W-3:0]),
    .denorm_i   (denorm_q),
    .data_o     (packed_word)
  );

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mag_d       = mag_q;
    rmode_d     = rmode_q;
    denorm_d    = denorm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = {{(EXP_INT_W-10){in_exp[9]}}, in_exp};
          mag_d    = in_mag;
          rmode_d  = in_rmode;
          denorm_d = 1'b0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (mag_q == '0) begin
          exp_d    = '0;
          denorm_d = 1'b1;
          state_d  = ST_PACK;
        end else if (mag_q[MAG_W-1] || (exp_q < 12'sd1)) begin
          if (exp_q < -MAG_W) begin
            // Everything would shift out before exp reaches 1: keep only sticky.
            mag_d = {{(MAG_W-1){1'b0}}, |mag_q};
            exp_d = 12'sd1;
          end else begin
            mag_d = {1'b0, mag_q[MAG_W-1:2], mag_q[1] | mag_q[0]};
            exp_d = exp_q + 12'sd1;
          end
        end else if (mag_q[MAG_W-2]) begin
          state_d = ST_PACK;
        end else if (exp_q == 12'sd1) begin
          denorm_d = 1'b1;
          state_d  = ST_PACK;
        end else begin
          mag_d = {mag_q[MAG_W-2:0], 1'b0};
          exp_d = exp_q - 12'sd1;
        end
      end

      ST_PACK: begin
        // First PACK cycle registers the formatted word; afterwards hold it
        // until the consumer takes it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = packed_word;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mag_q       <= '0;
      rmode_q     <= '0;
      denorm_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mag_q       <= mag_d;
      rmode_q     <= rmode_d;
      denorm_q    <= denorm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rmode = rmode_q;

endmodule
`default_nettype wire

// File: doc/float_normalizer.md
Name: float_normalizer

Overview:
- Post-arithmetic normalisation stage that sits directly upstream of the rounding stage.
- Accepts an unnormalised sign/exponent/magnitude result from the FP adder or multiplier and iteratively shifts it to put the hidden bit in place, adjusting the exponent.
- Handles carry-out, zero, subnormal and overflow cases.
- Emits a packed {sign, exp[7:0], frac} word of DATA_W bits, with the fraction LSB carrying sticky, plus the captured rounding mode.
- Uses a valid/ready handshake on both sides and processes one operation at a time.

Parameters:
- MAG_W, 34: input magnitude width. bit MAG_W-1 = carry, bit MAG_W-2 = hidden, remainder = fraction; MAG_W >= 26.
- DATA_W, 40: packed output width; frac field F = DATA_W-9 bits; DATA_W >= 33.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept; high only in IDLE
- in_sign  in  1  result sign
- in_exp  in  10  biased exponent, two's complement signed (may be <=0 or >254)
- in_mag  in  MAG_W  unnormalised magnitude
- in_rmode  in  2  rounding mode, passed through unchanged
- out_valid  out  1  packed result valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  [DATA_W-1]=sign, [DATA_W-2:DATA_W-9]=exp field, [DATA_W-10:0]=frac
- out_rmode  out  2  captured rounding mode

Behaviour:
- Reset: state=IDLE, out_valid=0, out_data=0, out_rmode=0, all internal registers cleared. in_ready=(state==IDLE). Reset mid-operation aborts the operation silently; no output is produced.
- IDLE: on in_valid&&in_ready, capture sign, exp (12-bit signed internal), mag, rmode → SHIFT.
- SHIFT: one step per cycle, conditions evaluated in priority order:
  1. mag==0 → exp=0, → PACK (signed zero).
  2. mag[MAG_W-1]==1 or exp<1 → right-shift by 1 with sticky (new bit0 = old bit1|old bit0), exp+1, stay.
     - Exception: if exp < -MAG_W, collapse to mag={0..,|mag} and exp=1 in one step.
  3. mag[MAG_W-2]==1 → PACK.
  4. exp==1 (hidden clear) → subnormal, → PACK with exp field 0.
  5. Otherwise left-shift by 1, exp-1, stay.
- PACK entry (registered):
  - exp field = 0 if subnormal or zero; 255 with frac=0 if exp>=255 (infinity); else exp[7:0].
  - frac: the MAG_W-2 bits below hidden, left-aligned into F bits.
    - If MAG_W-2 > F: the surplus low bits are ORed into frac LSB.
    - If MAG_W-2 < F: zero-pad below.
  - out_valid=1.
- PACK: out_data and out_rmode are held stable while out_valid&&!out_ready. On out_ready → out_valid=0, → IDLE.
- Latency (accept edge = edge 0):
  - Already normalised input: out_valid is high after edge 2.
  - Each shift step adds one edge.
  - Worst case ≈ MAG_W+3 edges.
- Throughput: no new accept until the output is taken, since in_ready is low outside IDLE. No simultaneous accept/emit.
- Right shift never loses a set bit, because of sticky; the zero path is taken only if the input magnitude was zero.

Decomposition:
- Shared package fp_norm_pkg:
  - FP32 constants: EXP_W=8, EXP_MAX=255, BIAS=127, FRAC_W=23.
  - State encoding IDLE/SHIFT/PACK.
  - Output field-offset constants (SIGN_POS, EXP_HI, EXP_LO).
- One natural sub-module: norm_pack (combinational PACK formatting: exp clamp, subnormal/zero/infinity select, frac alignment and sticky collapse). The FSM and shifter remain in float_normalizer.

Test Plan (defaults, F=31; frac = mag[31:1] with LSB |= mag[0]):
- 1.0 normalised: sign0, exp127, mag=1<<32 → out_valid after edge 2, out_data=0x3F_8000_0000, out_rmode = in_rmode.
- Left shifts: exp127, mag=1<<30 → two shifts, after edge 4 out_data=0x3E_8000_0000 (exp125, frac0).
- Carry and overflow:
  - exp127, mag=3<<32 → exp128, frac[30]=1, out_data=0x40_4000_0000.
  - exp254, mag=1<<33 → out_data=0x7F_8000_0000 (infinity).
- Zero and subnormal:
  - sign1, mag=0 → out_data=0x80_0000_0000.
  - exp1, mag=1<<31 → exp field 0, out_data=0x00_4000_0000.
  - exp=-2, mag=1<<32 → 3 right shifts, out_data=0x00_1000_0000.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles → out_data stable, in_ready=0, second in_valid ignored; release → IDLE next edge.
  - Assert rst during SHIFT → out_valid=0, out_data=0 immediately, in_ready=1 after deassert.
